// File: rtl/wrr_lock_arbiter.sv
// N-way weighted round-robin arbiter with packet locking.
// A holder keeps the grant for up to weight[g] packets, then priority rotates past it.
module wrr_lock_arbiter #(
   parameter int unsigned N  = 8,
   parameter int unsigned WW = 4,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    last,
   input  logic [N*WW-1:0] weight,
   output logic [N-1:0]    gnt,
   output logic [IW-1:0]   gnt_id,
   output logic            gnt_valid
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [IW-1:0] id_q, id_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [WW-1:0] credit_q, credit_d;

   logic [IW-1:0] next_ptr, base, off, pick;
   logic [IW:0]   sum;
   logic [N-1:0]  req_rot, pick_oh;
   logic [WW-1:0] w_sel, w_load;
   logic          found, hold_req, hold_last, rel;

   // Release decision for the current holder and the pointer it leaves behind.
   always_comb begin
      next_ptr  = (id_q == IW'(N - 1)) ? '0 : id_q + IW'(1);
      hold_req  = req[id_q];
      hold_last = last[id_q];
      rel       = ~hold_req | (hold_last & (credit_q == WW'(1)));
      base      = (state_q == StGrant) ? next_ptr : ptr_q;
   end

   // Rotate right by base through a double-width copy, take the lowest set bit,
   // then rotate the offset back, wrapping at N rather than 2^IW.
   always_comb begin
      req_rot = N'({req, req} >> base);
      found   = 1'b0;
      off     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            found = 1'b1;
            off   = IW'(i);
         end
      end
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= (IW + 1)'(N)) begin
         sum = sum - (IW + 1)'(N);
      end
      pick    = sum[IW-1:0];
      pick_oh = '0;
      pick_oh[pick] = 1'b1;
      w_sel = '0;
      for (int i = 0; i < N; i++) begin
         if (pick == IW'(i)) begin
            w_sel = weight[i*WW +: WW];
         end
      end
      w_load = (w_sel == '0) ? WW'(1) : w_sel;
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      id_d     = id_q;
      ptr_d    = ptr_q;
      credit_d = credit_q;
      case (state_q)
         StIdle: begin
            if (found) begin
               state_d  = StGrant;
               gnt_d    = pick_oh;
               id_d     = pick;
               credit_d = w_load;
            end
         end
         StGrant: begin
            if (!rel) begin
               if (hold_last) begin
                  credit_d = credit_q - WW'(1);
               end
            end else begin
               ptr_d = next_ptr;
               if (found) begin
                  gnt_d    = pick_oh;
                  id_d     = pick;
                  credit_d = w_load;
               end else begin
                  state_d  = StIdle;
                  gnt_d    = '0;
                  id_d     = '0;
                  credit_d = '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         gnt_q    <= '0;
         id_q     <= '0;
         ptr_q    <= '0;
         credit_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         id_q     <= id_d;
         ptr_q    <= ptr_d;
         credit_q <= credit_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = id_q;
   assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// Scoreboard bench for wrr_lock_arbiter: N=8 and N=5 instances against a
// packet-level reference model; directed scenarios followed by random traffic.
module tb_wrr_lock_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [7:0]  req8 = '0, last8 = '0, gnt8;
   logic [31:0] weight8;
   logic [2:0]  id8;
   logic        v8;

   logic [4:0]  req5 = '0, last5 = '0, gnt5;
   logic [19:0] weight5;
   logic [2:0]  id5;
   logic        v5;

   wrr_lock_arbiter #(.N(8), .WW(4)) dut8 (
      .clk(clk), .rst(rst), .req(req8), .last(last8), .weight(weight8),
      .gnt(gnt8), .gnt_id(id8), .gnt_valid(v8)
   );

   wrr_lock_arbiter #(.N(5), .WW(4)) dut5 (
      .clk(clk), .rst(rst), .req(req5), .last(last5), .weight(weight5),
      .gnt(gnt5), .gnt_id(id5), .gnt_valid(v5)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit active;
      int holder;
      int ptr;
      int credit;
   } mst_t;

   typedef struct {
      logic [7:0] gnt;
      int         id;
   } exp_t;

   mst_t        m8, m5;
   exp_t        q8[$], q5[$];
   exp_t        e8, e5;
   int          checks = 0;
   int          passes = 0;
   logic [31:0] nw8 = 32'h1111_1111;
   logic [19:0] nw5 = 20'h11111;
   logic [7:0]  rr8;
   logic [4:0]  rr5;

   function automatic int pick_fn(logic [7:0] r, int ptr, int n);
      for (int k = 0; k < n; k++) begin
         int idx;
         idx = (ptr + k) % n;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic int wload(logic [31:0] w, int i);
      int v;
      v = int'(w[i*4 +: 4]);
      return (v == 0) ? 1 : v;
   endfunction

   // One clock edge of the arbitration rules, at packet/credit granularity.
   function automatic mst_t step(mst_t s, int n, logic [7:0] r, logic [7:0] l, logic [31:0] w);
      mst_t t;
      int   p;
      t = s;
      if (!t.active) begin
         p = pick_fn(r, t.ptr, n);
         if (p >= 0) begin
            t.active = 1'b1;
            t.holder = p;
            t.credit = wload(w, p);
         end
      end else if (r[t.holder] && !(l[t.holder] && t.credit == 1)) begin
         if (l[t.holder]) t.credit = t.credit - 1;
      end else begin
         t.ptr = (t.holder + 1) % n;
         p = pick_fn(r, t.ptr, n);
         if (p >= 0) begin
            t.holder = p;
            t.credit = wload(w, p);
         end else begin
            t.active = 1'b0;
         end
      end
      return t;
   endfunction

   function automatic exp_t expect_of(mst_t s);
      exp_t e;
      e.gnt = s.active ? (8'(1) << s.holder) : 8'h00;
      e.id  = s.active ? s.holder : 0;
      return e;
   endfunction

   task automatic cycle(input logic [7:0] r8, input logic [7:0] l8,
                        input logic [4:0] r5, input logic [4:0] l5);
      @(negedge clk);
      weight8 = nw8;
      weight5 = nw5;
      req8 = r8;
      last8 = l8;
      req5 = r5;
      last5 = l5;
      m8 = step(m8, 8, r8, l8, weight8);
      m5 = step(m5, 5, {3'b000, r5}, {3'b000, l5}, {12'h000, weight5});
      q8.push_back(expect_of(m8));
      q5.push_back(expect_of(m5));
   endtask

   // Asynchronous reset asserted away from any clock edge while a grant is held.
   task automatic mid_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (gnt8 === 8'h00 && v8 === 1'b0 && id8 === 3'd0 &&
          gnt5 === 5'h00 && v5 === 1'b0 && id5 === 3'd0)
         passes++;
      else
         $display("FAIL rst_async @%0t: got gnt8=%h id8=%0d v8=%b gnt5=%h id5=%0d v5=%b, want all 0",
                  $time, gnt8, id8, v8, gnt5, id5, v5);
      req8 = '0;
      last8 = '0;
      req5 = '0;
      last5 = '0;
      m8 = '{0, 0, 0, 0};
      m5 = '{0, 0, 0, 0};
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: one expected response per clock edge, compared after the edge settles.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q8.size() > 0) begin
            e8 = q8.pop_front();
            checks++;
            if (gnt8 === e8.gnt && id8 === 3'(e8.id) && v8 === (e8.gnt != 8'h00))
               passes++;
            else
               $display("FAIL gnt8 @%0t: got gnt=%h id=%0d valid=%b, want gnt=%h id=%0d valid=%b",
                        $time, gnt8, id8, v8, e8.gnt, e8.id, e8.gnt != 8'h00);
         end
         if (q5.size() > 0) begin
            e5 = q5.pop_front();
            checks++;
            if (gnt5 === e5.gnt[4:0] && id5 === 3'(e5.id) && v5 === (e5.gnt != 8'h00))
               passes++;
            else
               $display("FAIL gnt5 @%0t: got gnt=%h id=%0d valid=%b, want gnt=%h id=%0d valid=%b",
                        $time, gnt5, id5, v5, e5.gnt[4:0], e5.id, e5.gnt != 8'h00);
         end
      end
   end

   initial begin
      weight8 = nw8;
      weight5 = nw5;
      m8 = '{0, 0, 0, 0};
      m5 = '{0, 0, 0, 0};
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Idle after reset.
      repeat (10) cycle(8'h00, 8'h00, 5'h00, 5'h00);

      // Single requester 3 with weight 2, last every third beat.
      nw8 = 32'h1111_2111;
      for (int i = 0; i < 13; i++)
         cycle(8'h08, (i > 0 && i % 3 == 0) ? 8'h08 : 8'h00, 5'h00, 5'h00);
      mid_reset();

      // Fairness: all weights 1, everyone requesting, single-beat packets.
      nw8 = 32'h1111_1111;
      repeat (18) cycle(8'hFF, 8'hFF, 5'h00, 5'h00);

      // Weighting: requester 0 weight 3 among four requesters.
      nw8 = 32'h1111_1113;
      repeat (14) cycle(8'h0F, 8'h0F, 5'h00, 5'h00);
      mid_reset();

      // Locking: 5-beat packet from 0; last on line 1 ignored meanwhile.
      nw8 = 32'h1111_1111;
      cycle(8'h03, 8'h00, 5'h00, 5'h00);
      repeat (4) cycle(8'h03, 8'h02, 5'h00, 5'h00);
      cycle(8'h03, 8'h03, 5'h00, 5'h00);
      repeat (3) cycle(8'h03, 8'h02, 5'h00, 5'h00);

      // N=5: holder 4 abandons, pointer wraps to 0; weight 0 acts as 1.
      nw5 = 20'h11110;
      cycle(8'h00, 8'h00, 5'h10, 5'h00);
      repeat (3) cycle(8'h00, 8'h00, 5'h11, 5'h00);
      cycle(8'h00, 8'h00, 5'h01, 5'h00);
      repeat (4) cycle(8'h00, 8'h00, 5'h01, 5'h01);
      repeat (6) cycle(8'h00, 8'h00, 5'h03, 5'h03);
      repeat (6) cycle(8'h00, 8'h00, 5'h19, 5'h19);

      // Random traffic with slowly changing requests and occasional weight changes.
      rr8 = 8'(0);
      rr5 = 5'(0);
      for (int i = 0; i < 600; i++) begin
         if (i % 50 == 0) begin
            nw8 = $urandom;
            nw5 = 20'($urandom);
         end
         rr8 = rr8 ^ 8'($urandom & $urandom & $urandom);
         rr5 = rr5 ^ 5'($urandom & $urandom & $urandom);
         if (i == 300 && m8.active) begin
            mid_reset();
            rr8 = 8'(0);
            rr5 = 5'(0);
         end
         cycle(rr8, rr8 & 8'($urandom), rr5, rr5 & 5'($urandom));
      end

      repeat (3) cycle(8'h00, 8'h00, 5'h00, 5'h00);
      repeat (2) @(negedge clk);
      checks++;
      if (q8.size() == 0 && q5.size() == 0)
         passes++;
      else
         $display("FAIL drain: got %0d/%0d pending, want 0/0", q8.size(), q5.size());

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
